// File: rtl/gtp_blk_rcv_if.sv
// Bundles the GTP receive word stream, the buffered output stream and the
// per-block status pulses of gtp_blk_rcv. clk and rst stay outside.
//
// Output stream handshake: a word moves from producer to consumer on every
// rising edge where dout_valid and dout_ready are both 1. The producer keeps
// dout stable and dout_valid high until that edge. dout_valid never depends
// combinationally on dout_ready. dout_ready while dout_valid is 0 does nothing.
interface gtp_blk_rcv_if #(
    parameter int ABITS = 11
);
    logic [15:0]  rx_data;
    logic         rx_kchar;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         blk_done;
    logic         err_undr;
    logic         err_ovr;
    logic         err_full;
    logic [ABITS:0] buf_words;
    logic [1:0]   state_dbg;

    // Deframer side
    modport slave (
        input  rx_data, rx_kchar, dout_ready,
        output dout, dout_valid, blk_done, err_undr, err_ovr, err_full,
               buf_words, state_dbg
    );

    // Link / consumer side
    modport master (
        output rx_data, rx_kchar, dout_ready,
        input  dout, dout_valid, blk_done, err_undr, err_ovr, err_full,
               buf_words, state_dbg
    );
endinterface

// File: rtl/gtp_blk_rcv.sv
// GTP block receiver: checks CW/payload framing on the channel-FPGA word
// stream, stores blocks in a circular buffer and releases only complete,
// error-free blocks on a registered valid/ready output.
// Write pointer is speculative; the commit pointer moves only when a block is
// complete, so a broken block is dropped by rewinding the write pointer.
// Optional statistics counters are enabled with `define GTP_BLK_RCV_STAT_EN.
module gtp_blk_rcv #(
    parameter int ABITS  = 11,
    parameter int MAXLEN = 511
) (
    input  logic           clk,
    input  logic           rst,
    gtp_blk_rcv_if.slave   bus
`ifdef GTP_BLK_RCV_STAT_EN
    ,
    input  logic           cnt_clr,
    output logic [15:0]    cnt_blk,
    output logic [15:0]    cnt_undr,
    output logic [15:0]    cnt_ovr,
    output logic [15:0]    cnt_full
`endif
);

    localparam int             DEPTH    = 1 << ABITS;
    localparam logic [ABITS:0] FULL_OCC = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS:0] ONE      = {{ABITS{1'b0}}, 1'b1};
    localparam logic [9:0]     MAXLEN_L = 10'(MAXLEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    logic [15:0] mem [DEPTH];

    state_t         state_q, state_d;
    logic [ABITS:0] wr_q, wr_d;
    logic [ABITS:0] cmt_q, cmt_d;
    logic [ABITS:0] cmt_vis_q, cmt_vis_d;
    logic [ABITS:0] rd_q, rd_d;
    logic [ABITS:0] fetch_q, fetch_d;
    logic [8:0]     rem_q, rem_d;
    logic [15:0]    dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           blk_done_q, blk_done_d;
    logic           err_undr_q, err_undr_d;
    logic           err_ovr_q, err_ovr_d;
    logic           err_full_q, err_full_d;

    logic             we;
    logic [ABITS-1:0] waddr;
    logic [ABITS:0]   base;
    logic [8:0]       n_len;
    logic             load;

    // Framing FSM and write side: validate each word, write it speculatively,
    // commit on block completion, rewind on any framing or space error.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        cmt_d      = cmt_q;
        rem_d      = rem_q;
        blk_done_d = 1'b0;
        err_undr_d = 1'b0;
        err_ovr_d  = 1'b0;
        err_full_d = 1'b0;
        we         = 1'b0;
        waddr      = wr_q[ABITS-1:0];
        base       = wr_q;
        n_len      = bus.rx_data[8:0];

        if (!bus.rx_kchar) begin
            if (bus.rx_data[15]) begin
                // A CW inside a block cuts it short: discard the partial block
                // and treat the CW as the start of a fresh one.
                if (state_q == PAYLOAD) begin
                    err_undr_d = 1'b1;
                    base       = cmt_q;
                end
                wr_d = base;
                if ({1'b0, n_len} > MAXLEN_L) begin
                    err_ovr_d = 1'b1;
                    state_d   = DROP;
                end else if ((base - rd_q) == FULL_OCC) begin
                    err_full_d = 1'b1;
                    wr_d       = cmt_q;
                    state_d    = DROP;
                end else begin
                    we    = 1'b1;
                    waddr = base[ABITS-1:0];
                    wr_d  = base + ONE;
                    rem_d = n_len;
                    if (n_len == 9'd0) begin
                        cmt_d      = base + ONE;
                        blk_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end else begin
                case (state_q)
                    PAYLOAD: begin
                        // Full wins over completion: the last word still needs a slot.
                        if ((wr_q - rd_q) == FULL_OCC) begin
                            err_full_d = 1'b1;
                            wr_d       = cmt_q;
                            state_d    = DROP;
                        end else begin
                            we    = 1'b1;
                            wr_d  = wr_q + ONE;
                            rem_d = rem_q - 9'd1;
                            if (rem_q == 9'd1) begin
                                cmt_d      = wr_q + ONE;
                                blk_done_d = 1'b1;
                                state_d    = IDLE;
                            end
                        end
                    end
                    IDLE:    err_ovr_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Read side: prefetch committed words into the output register. The commit
    // pointer is seen one cycle late so a new block appears two edges after
    // its final word. rd_ptr advances only when the consumer takes a word, so
    // the word held in dout still occupies buffer space.
    always_comb begin
        cmt_vis_d    = cmt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        load         = (!dout_valid_q || bus.dout_ready) && (fetch_q != cmt_vis_q);
        if (load) begin
            dout_d       = mem[fetch_q[ABITS-1:0]];
            dout_valid_d = 1'b1;
        end else if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end
        fetch_d = load ? (fetch_q + ONE) : fetch_q;
        rd_d    = (dout_valid_q && bus.dout_ready) ? (rd_q + ONE) : rd_q;
    end

    // State, pointers, output register and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_q         <= '0;
            cmt_q        <= '0;
            cmt_vis_q    <= '0;
            rd_q         <= '0;
            fetch_q      <= '0;
            rem_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            blk_done_q   <= 1'b0;
            err_undr_q   <= 1'b0;
            err_ovr_q    <= 1'b0;
            err_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            cmt_q        <= cmt_d;
            cmt_vis_q    <= cmt_vis_d;
            rd_q         <= rd_d;
            fetch_q      <= fetch_d;
            rem_q        <= rem_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            blk_done_q   <= blk_done_d;
            err_undr_q   <= err_undr_d;
            err_ovr_q    <= err_ovr_d;
            err_full_q   <= err_full_d;
        end
    end

    // Buffer storage; contents are meaningless until committed, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= bus.rx_data;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.blk_done   = blk_done_q;
    assign bus.err_undr   = err_undr_q;
    assign bus.err_ovr    = err_ovr_q;
    assign bus.err_full   = err_full_q;
    assign bus.buf_words  = cmt_q - rd_q;
    assign bus.state_dbg  = state_q;

`ifdef GTP_BLK_RCV_STAT_EN
    logic [15:0] cnt_blk_q, cnt_blk_d;
    logic [15:0] cnt_undr_q, cnt_undr_d;
    logic [15:0] cnt_ovr_q, cnt_ovr_d;
    logic [15:0] cnt_full_q, cnt_full_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? (v + 16'd1) : v;
    endfunction

    // Saturating event counters; clear wins over increment.
    always_comb begin
        cnt_blk_d  = sat_inc(cnt_blk_q, blk_done_q);
        cnt_undr_d = sat_inc(cnt_undr_q, err_undr_q);
        cnt_ovr_d  = sat_inc(cnt_ovr_q, err_ovr_q);
        cnt_full_d = sat_inc(cnt_full_q, err_full_q);
        if (cnt_clr) begin
            cnt_blk_d  = '0;
            cnt_undr_d = '0;
            cnt_ovr_d  = '0;
            cnt_full_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_blk_q  <= '0;
            cnt_undr_q <= '0;
            cnt_ovr_q  <= '0;
            cnt_full_q <= '0;
        end else begin
            cnt_blk_q  <= cnt_blk_d;
            cnt_undr_q <= cnt_undr_d;
            cnt_ovr_q  <= cnt_ovr_d;
            cnt_full_q <= cnt_full_d;
        end
    end

    assign cnt_blk  = cnt_blk_q;
    assign cnt_undr = cnt_undr_q;
    assign cnt_ovr  = cnt_ovr_q;
    assign cnt_full = cnt_full_q;
`endif

endmodule

// File: tb/tb_gtp_blk_rcv.sv
// Bench for gtp_blk_rcv: directed block scenarios followed by randomized
// block traffic, checked by a scoreboard fed from a word-level reference model.
module tb_gtp_blk_rcv;
  localparam int ABITS  = 4;
  localparam int MAXLEN = 100;
  localparam int DEPTH  = 1 << ABITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gtp_blk_rcv_if #(.ABITS(ABITS)) bus ();

`ifdef GTP_BLK_RCV_STAT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_blk, cnt_undr, cnt_ovr, cnt_full;
`endif

  gtp_blk_rcv #(.ABITS(ABITS), .MAXLEN(MAXLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GTP_BLK_RCV_STAT_EN
    ,
    .cnt_clr  (cnt_clr),
    .cnt_blk  (cnt_blk),
    .cnt_undr (cnt_undr),
    .cnt_ovr  (cnt_ovr),
    .cnt_full (cnt_full)
`endif
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         cyc;
    logic [3:0] pv;     // {blk_done, err_undr, err_ovr, err_full}
    int         added;  // words committed by this word
  } pulse_t;

  logic [15:0] exp_q[$];
  pulse_t      pulse_q[$];
  int checks = 0;
  int failures = 0;
  int consumed = 0;
  int mon_committed = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dout = '0;

  // Reference model: block = CW plus N payload words, held aside until whole.
  logic [15:0] pend_q[$];
  bit m_in_block = 0;
  bit m_dropping = 0;
  int m_rem = 0;
  int m_committed = 0;
  int m_nblk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int used_words();
    return m_committed - consumed + pend_q.size();
  endfunction

  function automatic void model_word(input logic kc, input logic [15:0] d,
                                     output logic [3:0] pv, output int added);
    int n;
    pv = 4'b0;
    added = 0;
    if (kc) return;
    if (d[15]) begin
      if (m_in_block) begin
        pv[2] = 1'b1;
        pend_q.delete();
        m_in_block = 0;
      end
      m_dropping = 0;
      n = int'(d[8:0]);
      if (n > MAXLEN) begin
        pv[1] = 1'b1;
        m_dropping = 1;
      end else if (used_words() == DEPTH) begin
        pv[0] = 1'b1;
        m_dropping = 1;
      end else begin
        pend_q.push_back(d);
        if (n == 0) begin
          added = pend_q.size();
        end else begin
          m_in_block = 1;
          m_rem = n;
        end
      end
    end else if (m_in_block) begin
      if (used_words() == DEPTH) begin
        pv[0] = 1'b1;
        pend_q.delete();
        m_in_block = 0;
        m_dropping = 1;
      end else begin
        pend_q.push_back(d);
        m_rem--;
        if (m_rem == 0) begin
          added = pend_q.size();
          m_in_block = 0;
        end
      end
    end else if (!m_dropping) begin
      pv[1] = 1'b1;
    end
    if (added > 0) begin
      pv[3] = 1'b1;
      m_nblk++;
      m_committed += added;
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic kc, input logic [15:0] d, input logic rdy);
    pulse_t e;
    @(posedge clk);
    #1;
    bus.rx_kchar   = kc;
    bus.rx_data    = d;
    bus.dout_ready = rdy;
    model_word(kc, d, e.pv, e.added);
    e.cyc = cyc + 1;
    pulse_q.push_back(e);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b1, 16'($urandom), rdy);
  endtask

  function automatic logic rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic logic [15:0] cw(input int ch, input int n);
    return {1'b1, 6'(ch), 9'(n)};
  endfunction

  function automatic logic [15:0] pw();
    return {1'b0, 15'($urandom)};
  endfunction

  task automatic send_block(input int ch, input int n, input int sent, input int rp);
    drive(1'b0, cw(ch, n), rnd(rp));
    for (int i = 0; i < sent; i++) begin
      if (rnd(20)) idle(rnd(rp));
      drive(1'b0, pw(), rnd(rp));
    end
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (i > 3 && exp_q.size() == 0 && !bus.dout_valid) break;
      idle(1'b1);
    end
    check({name, "_timeout"}, (i < 300), 1);
    check({name, "_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_dout"}, bus.dout, 0);
    check({name, "_dout_valid"}, bus.dout_valid, 0);
    check({name, "_blk_done"}, bus.blk_done, 0);
    check({name, "_errs"}, {bus.err_undr, bus.err_ovr, bus.err_full}, 0);
    check({name, "_buf_words"}, bus.buf_words, 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pulse_q.delete();
    pend_q.delete();
    m_in_block = 0;
    m_dropping = 0;
    m_rem = 0;
    m_committed = 0;
    m_nblk = 0;
    consumed = 0;
    mon_committed = 0;
  endtask

  // ---------------- monitor ----------------
  logic [3:0] mon_pv;
  int         mon_add;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      mon_pv = 4'b0;
      mon_add = 0;
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL pulse_stale: entry for cycle %0d seen at cycle %0d", pulse_q[0].cyc, cyc);
        void'(pulse_q.pop_front());
      end
      if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
        mon_pv = pulse_q[0].pv;
        mon_add = pulse_q[0].added;
        void'(pulse_q.pop_front());
      end
      mon_committed += mon_add;
      check("pulses", {bus.blk_done, bus.err_undr, bus.err_ovr, bus.err_full}, mon_pv);
      check("buf_words", bus.buf_words, mon_committed - consumed);
      if (prev_stall) begin
        check("stall_valid", bus.dout_valid, 1);
        check("stall_data", bus.dout, prev_dout);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dout_unexpected: got 0x%0h expected no word", bus.dout);
        end else begin
          check("dout", bus.dout, exp_q.pop_front());
        end
        consumed++;
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_kchar   = 1'b1;
    bus.rx_data    = '0;
    bus.dout_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("reset");
    check("reset_state", bus.state_dbg, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: basic block with commas inside, plus output latency
    drive(1'b0, 16'h8A03, 1'b1);
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 16'h0001, 1'b1);
    drive(1'b0, 16'h0002, 1'b1);
    drive(1'b0, 16'h0003, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("lat_early_valid", bus.dout_valid, 0);
    idle(1'b1);
    check("lat_valid", bus.dout_valid, 1);
    check("lat_first_word", bus.dout, 16'h8A03);
    drain("t1");
    check("t1_buf_words", bus.buf_words, 0);

    // 2: early CW truncates a block
    drive(1'b0, 16'h8004, 1'b1);
    drive(1'b0, 16'h0001, 1'b1);
    drive(1'b0, 16'h0002, 1'b1);
    drive(1'b0, 16'h8001, 1'b1);
    drive(1'b0, 16'h0007, 1'b1);
    drain("t2");

    // 3: stray payload and overlong CW, then a normal block
    drive(1'b0, 16'h1234, 1'b1);
    drive(1'b0, 16'h81FF, 1'b1);
    drive(1'b0, 16'h0042, 1'b1);
    drive(1'b0, 16'h8E01, 1'b1);
    drive(1'b0, 16'h0055, 1'b1);
    drain("t3");

    // 4: buffer full with consumer stalled
    drive(1'b0, cw(1, 9), 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 16'(16'h0100 + i), 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("t4_buf_words_first", bus.buf_words, 10);
    drive(1'b0, cw(2, 9), 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 16'(16'h0200 + i), 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("t4_buf_words_after_full", bus.buf_words, 10);
    check("t4_holding_first", bus.dout, cw(1, 9));
    drain("t4a");
    drive(1'b0, cw(4, 2), 1'b1);
    drive(1'b0, 16'h0A0A, 1'b1);
    drive(1'b0, 16'h0B0B, 1'b1);
    drain("t4b");

    // 5: consumer toggling ready every cycle
    drive(1'b0, cw(6, 8), 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 16'(16'h0300 + i), (i % 2) == 1);
    for (int i = 0; i < 30; i++) idle((i % 2) == 0);
    drain("t5");

    // 6: reset in the middle of a block
    drive(1'b0, cw(7, 5), 1'b1);
    drive(1'b0, 16'h0011, 1'b1);
    drive(1'b0, 16'h0012, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.rx_kchar = 1'b1;
    #1 check_zero("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, cw(12, 2), 1'b1);
    drive(1'b0, 16'h0021, 1'b1);
    drive(1'b0, 16'h0022, 1'b1);
    drain("t6");

    // Randomized traffic: whole, truncated, stray and overlong blocks
    for (int b = 0; b < 250; b++) begin
      int kind;
      int rp;
      int n;
      kind = $urandom_range(0, 99);
      rp = ($urandom_range(0, 2) == 0) ? 15 : 85;
      if (kind < 75) begin
        n = $urandom_range(0, 12);
        send_block($urandom_range(0, 63), n, n, rp);
      end else if (kind < 85) begin
        n = $urandom_range(2, 12);
        send_block($urandom_range(0, 63), n, $urandom_range(0, n - 1), rp);
      end else if (kind < 92) begin
        drive(1'b0, pw(), rnd(rp));
      end else begin
        drive(1'b0, cw($urandom_range(0, 63), $urandom_range(MAXLEN + 1, 511)), rnd(rp));
        drive(1'b0, pw(), rnd(rp));
      end
      repeat ($urandom_range(0, 3)) idle(rnd(rp));
    end
    drain("final");
    idle(1'b1);
    idle(1'b1);
    check("final_buf_words", bus.buf_words, 0);
`ifdef GTP_BLK_RCV_STAT_EN
    check("cnt_blk", cnt_blk, m_nblk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtp_blk_rcv.md
Name: gtp_blk_rcv

Overview:
- Receive-side deframer for the channel-FPGA GTP link, on the master FPGA side.
- Consumes the 16-bit word/k-char stream produced by the channel FPGA sending arbiter.
- Validates block framing, stores whole blocks in a circular buffer and releases only complete, error-free blocks to the downstream event builder over a valid/ready stream.
- Partial and corrupt blocks never reach the output.

Parameters:
ABITS, 11, buffer address width; depth = 2**ABITS 16-bit words (power of two).
MAXLEN, 511, largest legal payload length; longer CW length fields are treated as overrun errors.

Ports:
clk  input  1  GTP receive clock, 125 MHz; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
rx_data  input  16  word from GTP receiver.
rx_kchar  input  1  1 = comma/idle (rx_data ignored).
dout  output  16  buffered block word.
dout_valid  output  1  dout holds a committed word.
dout_ready  input  1  consumer accepts dout this cycle.
blk_done  output  1  one-cycle pulse: a block was committed.
err_undr  output  1  one-cycle pulse: CW arrived before the current block ended.
err_ovr  output  1  one-cycle pulse: data word outside a block, or CW length > MAXLEN.
err_full  output  1  one-cycle pulse: block dropped because the buffer had no space.
buf_words  output  ABITS+1  committed words not yet read.

Behaviour:
- Word format (non-comma):
  - CW: bit15=1, [14:9] = channel number, [8:0] = N payload words following.
  - Payload word: bit15=0.
- Commas are idle. They are skipped anywhere, including mid-block: the block stalls, no error.
- Pointers: wr_ptr (speculative write), cmt_ptr (commit), rd_ptr (read). All are ABITS+1 bits and wrap modulo 2**(ABITS+1). Occupancy = wr_ptr - rd_ptr. The full check uses this difference.
- FSM states: IDLE, PAYLOAD, DROP. Reset state is IDLE.
- IDLE:
  - CW with N <= MAXLEN: write CW, load remaining counter = N.
    - N=0: commit immediately (cmt_ptr <= wr_ptr+1, blk_done pulse) and stay in IDLE.
    - Otherwise go to PAYLOAD.
  - CW with N > MAXLEN: err_ovr, go to DROP.
  - Payload word: err_ovr, word discarded.
- PAYLOAD:
  - Payload word: write it, decrement remaining.
  - When remaining reaches 0 on this word: cmt_ptr <= wr_ptr+1, blk_done, go to IDLE.
  - CW: err_undr, wr_ptr <= cmt_ptr (rewind). The new CW is then processed as in IDLE in the same cycle.
- DROP: discard payload words. A CW is processed as in IDLE.
- Full: a word to be written while occupancy = 2**ABITS causes err_full, wr_ptr <= cmt_ptr, go to DROP.
  - Full takes priority over completion on the same word.
  - A block longer than the buffer is always dropped.
- Simultaneous read and write when full: the read frees space only from the next cycle; the write still sees full.
- Output:
  - dout/dout_valid are registered (prefetch). Throughput is 1 word/cycle while committed data is available.
  - The first word of a newly committed block has dout_valid high after the 2nd rising edge following the edge that sampled the final word (the CW if N=0), provided the output was empty.
  - dout is held stable while dout_valid=1 and dout_ready=0.
  - dout_ready with dout_valid=0 has no effect.
- Reset values: dout=0, dout_valid=0, blk_done=0, all err_*=0, buf_words=0, all pointers=0, FSM=IDLE.
- Reset mid-block: the partial block and all buffered data are lost. No pulses are issued for them.

Optional Feature:
- Macro: GTP_BLK_RCV_STAT_EN.
- Defined:
  - Adds outputs cnt_blk, cnt_undr, cnt_ovr, cnt_full, each 16 bits, counting the matching pulses.
  - Counters saturate at 16'hFFFF.
  - Adds input cnt_clr (synchronous clear, priority over increment).
  - All counters reset to 0.
- Undefined: none of these ports or logic exist. Core behaviour is identical.

Test Plan:
1. CW 16'h8A03 (ch 5, N=3), commas, then 0x0001, 0x0002, 0x0003, dout_ready=1 → blk_done once; dout sequence 8A03,0001,0002,0003; buf_words returns to 0.
2. CW N=4, two payload words, then CW 16'h8001 and word 0x0007 → err_undr once; the first block never appears; output is 8001,0007.
3. Payload word 0x1234 in IDLE; then CW with N=0x1FF while MAXLEN=100 → err_ovr twice; nothing output; the next valid block is received normally.
4. ABITS=4, dout_ready=0: a block of 1+9 words commits, then a block of 1+9 words arrives → err_full on its 7th word; buf_words=10; after draining, a new 1+2 block passes.
5. dout_ready toggled 1/0 every cycle during a 1+8 block → dout stable while stalled; all 9 words delivered in order with none duplicated.
6. rst asserted in the middle of PAYLOAD → all outputs 0 immediately; the next complete block after release is received correctly.
